prog_mem_loadable: RTL

//  Parametrised, writable program memory that succeeds the fixed asynchronous instruction ROM.
//  It supplies the CPU fetch stage with decoded instruction fields (op, rs, rt, rd, imm).

---
 rtl/prog_mem_pkg.sv | 26 ++
 rtl/prog_mem_array.sv | 37 +++
 rtl/prog_mem_loadable.sv | 130 +++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared instruction-word constants and loader FSM encoding for prog_mem_loadable
// and the CPU decoder.
package prog_mem_pkg;

  localparam int unsigned OpW    = 4;
  localparam int unsigned RegW   = 3;
  localparam int unsigned ImmW   = 8;
  localparam int unsigned InstrW = OpW + 3 * RegW + ImmW;

  // Field LSB offsets within {op, rs, rt, rd, imm}
  localparam int unsigned ImmLsb = 0;
  localparam int unsigned RdLsb  = ImmLsb + ImmW;
  localparam int unsigned RtLsb  = RdLsb + RegW;
  localparam int unsigned RsLsb  = RtLsb + RegW;
  localparam int unsigned OpLsb  = RsLsb + RegW;

  typedef enum logic {
    StIdle = 1'b0,
    StLoad = 1'b1
  } ld_state_e;

  function automatic int unsigned nbytes(input int unsigned width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Simple dual-port RAM: one write port, one synchronous read port with resettable
// output register.
module prog_mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between fetches so the fields stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_loadable.sv
// Writable program memory with byte-serial loader and decoded-field fetch port.
module prog_mem_loadable
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OP_W   = OpW,
  parameter int unsigned REG_W  = RegW,
  parameter int unsigned IMM_W  = ImmW
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchValid,
  output logic [OP_W-1:0]   DataOp,
  output logic [REG_W-1:0]  Datars,
  output logic [REG_W-1:0]  Datart,
  output logic [REG_W-1:0]  Datard,
  output logic [IMM_W-1:0]  Datai,
  input  logic              LdStart,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [7:0]        LdByte,
  input  logic              LdByteValid,
  input  logic              LdStop,
  output logic              LdReady,
  output logic              Busy,
  output logic [ADDR_W:0]   WordsLoaded
);

  localparam int unsigned INSTR_W = OP_W + 3 * REG_W + IMM_W;
  localparam int unsigned NBYTES  = nbytes(INSTR_W);
  localparam int unsigned CNT_W   = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LastByte = CNT_W'(NBYTES - 1);
  localparam logic [ADDR_W:0]  WordsMax = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e          state_q;
  logic               fetch_valid_q;
  logic               busy_q;
  logic               ldready_q;
  logic [ADDR_W-1:0]  wptr_q;
  logic [CNT_W-1:0]   bytecnt_q;
  logic [ADDR_W:0]    words_q;
  // Only the low INSTR_W-8 bits of earlier bytes can reach the word; the rest drop out.
  logic [INSTR_W-9:0] asm_q;

  logic               accept;
  logic               last_byte;
  logic               we;
  logic               re;
  logic [INSTR_W-1:0] wdata;
  logic [INSTR_W-1:0] rdata;

  always_comb begin
    accept    = (state_q == StLoad) && LdByteValid;
    last_byte = accept && (bytecnt_q == LastByte);
    we        = last_byte && !LdStart && Rst_n;
    re        = FetchReq && (state_q == StIdle) && Rst_n;
    wdata     = {asm_q, LdByte};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= StIdle;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      ldready_q     <= 1'b0;
      wptr_q        <= '0;
      bytecnt_q     <= '0;
      words_q       <= '0;
      asm_q         <= '0;
    end else begin
      fetch_valid_q <= re;
      if (LdStart) begin
        // Start from IDLE or restart inside LOAD; LdStart overrides LdStop.
        state_q   <= StLoad;
        busy_q    <= 1'b1;
        ldready_q <= 1'b1;
        wptr_q    <= LdAddr;
        bytecnt_q <= '0;
        words_q   <= '0;
        asm_q     <= '0;
      end else if (state_q == StLoad) begin
        if (accept) begin
          asm_q <= (INSTR_W - 8)'(wdata);
          if (last_byte) begin
            wptr_q    <= wptr_q + 1'b1;
            bytecnt_q <= '0;
            if (words_q != WordsMax) begin
              words_q <= words_q + 1'b1;
            end
          end else begin
            bytecnt_q <= bytecnt_q + 1'b1;
          end
        end
        if (LdStop) begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          ldready_q <= 1'b0;
          bytecnt_q <= '0;
        end
      end
    end
  end

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_array (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (re),
    .raddr (FetchAddr),
    .rdata (rdata)
  );

  assign FetchValid  = fetch_valid_q;
  assign Busy        = busy_q;
  assign LdReady     = ldready_q;
  assign WordsLoaded = words_q;

  assign DataOp = rdata[INSTR_W-1 -: OP_W];
  assign Datars = rdata[3*REG_W+IMM_W-1 -: REG_W];
  assign Datart = rdata[2*REG_W+IMM_W-1 -: REG_W];
  assign Datard = rdata[REG_W+IMM_W-1 -: REG_W];
  assign Datai  = rdata[IMM_W-1:0];

endmodule
